comp_b_responder: RTL
=====================

// Module: comp_b_responder
// PURPOSE
//   Responder end of the "b" result interface. Accepts an operand pair and samples b_operation on the
//   a-side handshake. Computes the result, single-cycle or iterative. Returns b_result with a b_valid/b_ready
//   handshake. It is the design-side counterpart of the verif_comp_b consumer: it drives b_valid/b_result
//   and receives b_ready/b_operation.
// PARAMETERS
//   OPW   16   operand width (a_op0, a_op1); legal range 4..16
//   RESW  32   result width; must be >= 2*OPW
// PORTS
//   clk          in   1     single clock, all state on rising edge
//   rst          in   1     asynchronous, active-high reset
//   a_valid      in   1     operand pair valid
//   a_ready      out  1     responder can accept an operand pair
//   a_op0        in   OPW   operand 0, unsigned
//   a_op1        in   OPW   operand 1, unsigned
//   b_operation  in   3     opcode, sampled only when a_valid && a_ready
//   b_valid      out  1     result valid
//   b_ready      in   1     consumer accepts result
//   b_result     out  RESW  result, stable while b_valid && !b_ready
// BEHAVIOUR
//   Reset (async, active-high):
//     - state=IDLE, a_ready=0 during reset, 1 on first edge after release.
//     - b_valid=0, b_result=0, acc=0, mul counter=0.
//   FSM IDLE -> CALC -> OUT -> IDLE:
//     - IDLE: a_ready=1. On a_valid&&a_ready, latch op0/op1/opcode. Opcode MUL goes to CALC; all others
//       compute and go directly to OUT.
//     - CALC: a_ready=0. Shift-add multiply, one operand bit per cycle, OPW cycles, then OUT.
//     - OUT: b_valid=1, a_ready=0. Stay until b_ready; on b_valid&&b_ready go to IDLE.
//       b_valid falls the next cycle. a_ready=1 the cycle after the handshake, so there is no
//       back-to-back acceptance.
//   Latency (accept edge N):
//     - non-MUL: b_valid high after edge N+1.
//     - MUL: b_valid high after edge N+1+OPW.
//   Opcodes (operands zero-extended to RESW, all arithmetic mod 2^RESW):
//     - 0 ADD: op0+op1
//     - 1 SUB: op0-op1, two's complement wrap
//     - 2 AND: op0&op1
//     - 3 OR:  op0|op1
//     - 4 XOR: op0^op1
//     - 5 MUL: op0*op1, exact since RESW >= 2*OPW
//     - 6 ACC: acc <= acc+op0+op1, wraps; result = new acc
//     - 7 CLR: acc <= 0; result = 0
//   acc updates at entry to OUT, never on replay/stall; b_result never changes while b_valid=1.
//   b_ready while b_valid=0 is ignored. b_operation changes outside the a-handshake are ignored.
//   a_valid held high in CALC/OUT is not consumed; the pair is taken in the next IDLE cycle.
//   MUL with op0 or op1 = 0 still takes OPW cycles (fixed latency).
//   Reset mid-CALC or mid-OUT: in-flight result is discarded, no b_valid after release, acc=0.
// CONFIGURATION
//   COMP_B_STATS_EN defined:
//     - adds output stat_count[15:0], +1 on each b_valid&&b_ready.
//     - saturates at 16'hFFFF; reset to 0; CLR does not clear it.
//   Undefined: port and counter absent, behaviour otherwise identical.
// TESTING
//   1. ADD: op0=16'h0003, op1=16'h0004, opcode 0, b_ready=1 -> b_result=32'h7, b_valid 1 cycle after accept.
//   2. SUB wrap: op0=1, op1=2, opcode 1 -> b_result=32'hFFFF_FFFF.
//   3. MUL: op0=16'hFFFF, op1=16'hFFFF -> b_result=32'hFFFE_0001, b_valid high 17 cycles after accept.
//   4. ACC 5+5 three times, then CLR:
//        - results 10, 20, 30;
//        - CLR -> 0;
//        - next ACC 1+1 -> 2.
//   5. Backpressure: hold b_ready=0 for 20 cycles with XOR 16'hA5A5^16'h5A5A ->
//        - b_result=32'hFFFF stable, b_valid held, a_ready=0 throughout.
//   6. Assert rst 5 cycles into MUL ->
//        - b_valid=0 and acc=0 immediately;
//        - a_ready=1 first edge after release;
//        - stat_count=0 (if STATS_EN).

Source files
------------

// File: rtl/comp_b_responder.sv
// comp_b_responder: responder end of the "b" result interface.
// Accepts an operand pair plus opcode on the a-side handshake, computes the
// result (single pass, or shift-add multiply over OPW cycles) and returns it
// on the b_valid/b_ready handshake.
// Optional build macro COMP_B_STATS_EN adds a saturating stat_count output
// that counts completed result handshakes.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | a_ready high, waiting for an operand pair
// S_CALC | shift-add multiply, one multiplier bit per cycle
// S_OUT  | first cycle loads result/acc, then b_valid held until b_ready
module comp_b_responder #(
   parameter int OPW  = 16,
   parameter int RESW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [OPW-1:0]  a_op0,
   input  logic [OPW-1:0]  a_op1,
   input  logic [2:0]      b_operation,
   output logic            b_valid,
   input  logic            b_ready,
   output logic [RESW-1:0] b_result
`ifdef COMP_B_STATS_EN
   ,
   output logic [15:0]     stat_count
`endif
);

   localparam int CW = $clog2(OPW + 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_ACC = 3'd6;
   localparam logic [2:0] OP_CLR = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_OUT
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [2:0]      opcode_q;
   logic [OPW-1:0]  op0_q;
   logic [OPW-1:0]  op1_q;
   logic [RESW-1:0] mcand;
   logic [OPW-1:0]  mplier;
   logic [RESW-1:0] prod;
   logic [CW-1:0]   mul_cnt;
   logic [RESW-1:0] acc;
   logic [RESW-1:0] x0;
   logic [RESW-1:0] x1;
   logic [RESW-1:0] result_nxt;
   logic [RESW-1:0] acc_nxt;
   logic            accept;

   assign accept = a_valid && a_ready;
   assign x0     = {{(RESW-OPW){1'b0}}, op0_q};
   assign x1     = {{(RESW-OPW){1'b0}}, op1_q};

   // Next-state decode; mul_cnt is a down-counter and 1 marks the last multiply step.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = (b_operation == OP_MUL) ? S_CALC : S_OUT;
         S_CALC: if (mul_cnt == CW'(1)) state_nxt = S_OUT;
         S_OUT:  if (b_valid && b_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Result and accumulator update, applied once on the first OUT cycle.
   always_comb begin
      result_nxt = '0;
      acc_nxt    = acc;
      case (opcode_q)
         OP_ADD: result_nxt = x0 + x1;
         OP_SUB: result_nxt = x0 - x1;
         OP_AND: result_nxt = x0 & x1;
         OP_OR:  result_nxt = x0 | x1;
         OP_XOR: result_nxt = x0 ^ x1;
         OP_MUL: result_nxt = prod;
         OP_ACC: begin
            acc_nxt    = acc + x0 + x1;
            result_nxt = acc_nxt;
         end
         OP_CLR: begin
            acc_nxt    = '0;
            result_nxt = '0;
         end
         default: result_nxt = '0;
      endcase
   end

   // State register; a_ready is registered so it stays low while rst is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         a_ready <= 1'b0;
      end else begin
         state   <= state_nxt;
         a_ready <= (state_nxt == S_IDLE);
      end
   end

   // Operand capture, shift-add multiply and result/handshake registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode_q <= '0;
         op0_q    <= '0;
         op1_q    <= '0;
         mcand    <= '0;
         mplier   <= '0;
         prod     <= '0;
         mul_cnt  <= '0;
         acc      <= '0;
         b_valid  <= 1'b0;
         b_result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  opcode_q <= b_operation;
                  op0_q    <= a_op0;
                  op1_q    <= a_op1;
                  mcand    <= {{(RESW-OPW){1'b0}}, a_op0};
                  mplier   <= a_op1;
                  prod     <= '0;
                  mul_cnt  <= CW'(OPW);
               end
            end
            S_CALC: begin
               mul_cnt <= mul_cnt - 1'b1;
               if (mplier[0]) prod <= prod + mcand;
               mcand   <= mcand << 1;
               mplier  <= mplier >> 1;
            end
            S_OUT: begin
               if (!b_valid) begin
                  b_valid  <= 1'b1;
                  b_result <= result_nxt;
                  acc      <= acc_nxt;
               end else if (b_ready) begin
                  b_valid <= 1'b0;
               end
            end
            default: b_valid <= 1'b0;
         endcase
      end
   end

`ifdef COMP_B_STATS_EN
   // Saturating count of completed result handshakes; CLR leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_count <= '0;
      end else if (b_valid && b_ready && (stat_count != 16'hFFFF)) begin
         stat_count <= stat_count + 16'd1;
      end
   end
`endif

endmodule
